// File: rtl/datapath_pkg.sv
// Shared encodings for the single-bus datapath: bus sources, ALU operations,
// mul/div engine states and branch-condition codes.
package datapath_pkg;

    typedef enum logic [3:0] {
        SRC_RSEL  = 4'd0,
        SRC_HI    = 4'd1,
        SRC_LO    = 4'd2,
        SRC_ZHI   = 4'd3,
        SRC_ZLO   = 4'd4,
        SRC_PC    = 4'd5,
        SRC_MDR   = 4'd6,
        SRC_IN    = 4'd7,
        SRC_CSIGN = 4'd8,
        SRC_Y     = 4'd9,
        SRC_MAR   = 4'd10
    } bus_src_e;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_SHR  = 4'd4,
        ALU_SHRA = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_ROR  = 4'd7,
        ALU_ROL  = 4'd8,
        ALU_NEG  = 4'd9,
        ALU_NOT  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    typedef enum logic [1:0] {
        COND_ZERO    = 2'd0,
        COND_NONZERO = 2'd1,
        COND_POS     = 2'd2,
        COND_NEG     = 2'd3
    } cond_e;

    // Position of the two-bit branch condition field inside IR.
    localparam int unsigned COND_LSB = 19;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative signed multiply/divide engine. Works on operand magnitudes for
// WIDTH cycles, then applies signs in a final FIX cycle while the caller
// writes the {hi,lo} result.
module muldiv_iter
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             res_we,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    md_state_e        state;
    logic             op_div;
    logic             div0;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_keep;
    logic [WIDTH-1:0] mb;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_signed;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    // One shift-add (multiply) or shift-subtract (restoring divide) step.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mb} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, mb};
    end

    // Handshake FSM with operand latch and iteration datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= MD_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            op_div <= 1'b0;
            div0   <= 1'b0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            a_keep <= '0;
            mb     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        op_div <= div;
                        a_keep <= a;
                        a_neg  <= a[WIDTH-1];
                        b_neg  <= b[WIDTH-1];
                        mb     <= mag(b);
                        acc_hi <= '0;
                        acc_lo <= mag(a);
                        cnt    <= '0;
                        busy   <= 1'b1;
                        div0   <= div && (b == '0);
                        state  <= (div && (b == '0)) ? MD_FIX : MD_RUN;
                    end
                end
                MD_RUN: begin
                    if (op_div) begin
                        if (!div_trial[WIDTH]) begin
                            acc_hi <= div_trial[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= MD_FIX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                MD_FIX: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sign correction of the magnitude result, presented during FIX.
    always_comb begin
        res_we      = (state == MD_FIX);
        prod        = {acc_hi, acc_lo};
        prod_signed = (a_neg ^ b_neg) ? -prod : prod;
        if (div0) begin
            res_lo = '1;
            res_hi = a_keep;
        end else if (op_div) begin
            res_lo = (a_neg ^ b_neg) ? -acc_lo : acc_lo;
            res_hi = a_neg ? -acc_hi : acc_hi;
        end else begin
            res_lo = prod_signed[WIDTH-1:0];
            res_hi = prod_signed[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/bus_datapath_p.sv
// Single-bus CPU datapath: register file, special registers, ALU and the
// iterative mul/div engine, all exchanging data over one shared bus.
module bus_datapath_p
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               bus_src,
    input  logic [$clog2(NREGS)-1:0] rsel_out,
    input  logic                     reg_we,
    input  logic [$clog2(NREGS)-1:0] rsel_in,
    input  logic                     ba_out,
    input  logic                     y_in,
    input  logic                     z_in,
    input  logic                     hi_in,
    input  logic                     lo_in,
    input  logic                     pc_in,
    input  logic                     ir_in,
    input  logic                     mar_in,
    input  logic                     mdr_in,
    input  logic                     con_in,
    input  logic                     out_in,
    input  logic                     inc_pc,
    input  logic                     read,
    input  logic [3:0]               alu_op,
    input  logic                     md_start,
    input  logic                     md_div,
    output logic                     md_busy,
    output logic                     md_done,
    input  logic [WIDTH-1:0]         mem_rdata,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [WIDTH-1:0]         csign,
    output logic [WIDTH-1:0]         bus,
    output logic [WIDTH-1:0]         mar,
    output logic [WIDTH-1:0]         mdr,
    output logic [WIDTH-1:0]         ir,
    output logic [WIDTH-1:0]         out_data
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] z_hi;
    logic [WIDTH-1:0] z_lo;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] in_reg;
    logic             con;

    logic [WIDTH-1:0]   alu_lo;
    logic [WIDTH-1:0]   alu_hi;
    logic [SHW-1:0]     shamt;
    logic [SHW-1:0]     rot_amt;
    logic [2*WIDTH-1:0] rot_src;
    logic [1:0]         cond_bits;
    logic               cond_true;

    logic             md_we;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .div    (md_div),
        .a      (y_reg),
        .b      (bus),
        .busy   (md_busy),
        .done   (md_done),
        .res_we (md_we),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    // Bus driver selection; R0 reads as zero when ba_out is set.
    always_comb begin
        bus = '0;
        case (bus_src_e'(bus_src))
            SRC_RSEL:  bus = (ba_out && (rsel_out == '0)) ? '0 : regs[rsel_out];
            SRC_HI:    bus = hi_reg;
            SRC_LO:    bus = lo_reg;
            SRC_ZHI:   bus = z_hi;
            SRC_ZLO:   bus = z_lo;
            SRC_PC:    bus = pc_reg;
            SRC_MDR:   bus = read ? mem_rdata : mdr;
            SRC_IN:    bus = in_reg;
            SRC_CSIGN: bus = csign;
            SRC_Y:     bus = y_reg;
            SRC_MAR:   bus = mar;
            default:   bus = '0;
        endcase
    end

    // Rotate distance reduced modulo WIDTH for non-power-of-two widths.
    always_comb begin
        shamt   = bus[SHW-1:0];
        rot_amt = shamt;
        if (32'(shamt) >= WIDTH) begin
            rot_amt = shamt - SHW'(WIDTH);
        end
        rot_src = {y_reg, y_reg};
    end

    // Single-cycle ALU: A is Y, B is the bus.
    always_comb begin
        alu_lo = '0;
        alu_hi = '0;
        case (alu_op_e'(alu_op))
            ALU_AND:  alu_lo = y_reg & bus;
            ALU_OR:   alu_lo = y_reg | bus;
            ALU_ADD:  alu_lo = y_reg + bus;
            ALU_SUB:  alu_lo = y_reg - bus;
            ALU_SHR:  alu_lo = y_reg >> shamt;
            ALU_SHRA: alu_lo = $signed(y_reg) >>> shamt;
            ALU_SHL:  alu_lo = y_reg << shamt;
            ALU_ROR:  alu_lo = WIDTH'(rot_src >> rot_amt);
            // Rotate left by s equals the low half of {Y,Y} shifted right by WIDTH-s.
            ALU_ROL:  alu_lo = WIDTH'(rot_src >> (WIDTH - 32'(rot_amt)));
            ALU_NEG: begin
                alu_lo = -bus;
                alu_hi = {WIDTH{alu_lo[WIDTH-1]}};
            end
            ALU_NOT:  alu_lo = ~bus;
            default: begin
                alu_lo = '0;
                alu_hi = '0;
            end
        endcase
    end

    // Narrow datapaths have no condition field in IR and always test for zero.
    if (WIDTH > COND_LSB + 1) begin : g_cond_field
        assign cond_bits = ir[COND_LSB+1:COND_LSB];
    end else begin : g_cond_none
        assign cond_bits = 2'b00;
    end

    // Branch condition evaluated on the current bus value.
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond_bits))
            COND_ZERO:    cond_true = (bus == '0);
            COND_NONZERO: cond_true = (bus != '0);
            COND_POS:     cond_true = !bus[WIDTH-1] && (bus != '0);
            COND_NEG:     cond_true = bus[WIDTH-1];
            default:      cond_true = 1'b0;
        endcase
    end

    // General register file written from the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[rsel_in] <= bus;
        end
    end

    // Z pair: the mul/div completion write takes priority over z_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            z_hi <= '0;
            z_lo <= '0;
        end else if (md_we) begin
            z_hi <= md_hi;
            z_lo <= md_lo;
        end else if (z_in) begin
            z_hi <= alu_hi;
            z_lo <= alu_lo;
        end
    end

    // Data registers loaded from the bus or memory, plus the IN sampler.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_reg    <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            ir       <= '0;
            mdr      <= '0;
            out_data <= '0;
            in_reg   <= '0;
        end else begin
            in_reg <= in_data;
            if (y_in)   y_reg    <= bus;
            if (hi_in)  hi_reg   <= bus;
            if (lo_in)  lo_reg   <= bus;
            if (ir_in)  ir       <= bus;
            if (out_in) out_data <= bus;
            if (mdr_in) mdr      <= read ? mem_rdata : bus;
        end
    end

    // Program counter, memory address and branch condition flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= '0;
            mar    <= '0;
            con    <= 1'b0;
        end else begin
            if (pc_in) begin
                if (inc_pc) begin
                    pc_reg <= pc_reg + WIDTH'(1) + (con ? csign : '0);
                end else begin
                    pc_reg <= bus;
                end
            end
            if (mar_in) begin
                mar <= inc_pc ? pc_reg : bus;
            end
            if (con_in) begin
                con <= cond_true;
            end
        end
    end

endmodule

// File: tb/tb_bus_datapath_p.sv
// Self-checking bench for bus_datapath_p (WIDTH=32, NREGS=16).
module tb_bus_datapath_p;
    import datapath_pkg::*;

    localparam int unsigned W = 32;
    localparam int unsigned N = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    bus_src;
    logic [3:0]    rsel_out;
    logic          reg_we;
    logic [3:0]    rsel_in;
    logic          ba_out;
    logic          y_in, z_in, hi_in, lo_in, pc_in, ir_in;
    logic          mar_in, mdr_in, con_in, out_in, inc_pc, read;
    logic [3:0]    alu_op;
    logic          md_start, md_div;
    logic          md_busy, md_done;
    logic [W-1:0]  mem_rdata, in_data, csign;
    logic [W-1:0]  bus, mar, mdr, ir, out_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bus_datapath_p #(
        .WIDTH (W),
        .NREGS (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_src   (bus_src),
        .rsel_out  (rsel_out),
        .reg_we    (reg_we),
        .rsel_in   (rsel_in),
        .ba_out    (ba_out),
        .y_in      (y_in),
        .z_in      (z_in),
        .hi_in     (hi_in),
        .lo_in     (lo_in),
        .pc_in     (pc_in),
        .ir_in     (ir_in),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .con_in    (con_in),
        .out_in    (out_in),
        .inc_pc    (inc_pc),
        .read      (read),
        .alu_op    (alu_op),
        .md_start  (md_start),
        .md_div    (md_div),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .mem_rdata (mem_rdata),
        .in_data   (in_data),
        .csign     (csign),
        .bus       (bus),
        .mar       (mar),
        .mdr       (mdr),
        .ir        (ir),
        .out_data  (out_data)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
    } alu_vec_t;

    alu_vec_t tbl [18];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_src = 4'd0; rsel_out = '0; reg_we = 1'b0; rsel_in = '0; ba_out = 1'b0;
        y_in = 1'b0; z_in = 1'b0; hi_in = 1'b0; lo_in = 1'b0; pc_in = 1'b0; ir_in = 1'b0;
        mar_in = 1'b0; mdr_in = 1'b0; con_in = 1'b0; out_in = 1'b0; inc_pc = 1'b0;
        read = 1'b0; alu_op = 4'd0; md_start = 1'b0; md_div = 1'b0;
    endtask

    task automatic drive(input logic [W-1:0] v);
        bus_src = SRC_CSIGN;
        csign   = v;
    endtask

    task automatic peek(input logic [3:0] src, output logic [W-1:0] v);
        bus_src = src;
        #1;
        v = bus;
    endtask

    task automatic load_y(input logic [W-1:0] v);
        idle(); drive(v); y_in = 1'b1; tick(); idle();
    endtask

    task automatic write_reg(input logic [3:0] r, input logic [W-1:0] v);
        idle(); drive(v); reg_we = 1'b1; rsel_in = r; tick(); idle();
    endtask

    task automatic alu_run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] lo, output logic [W-1:0] hi);
        load_y(a);
        drive(b); alu_op = op; z_in = 1'b1; tick(); idle();
        peek(SRC_ZLO, lo);
        peek(SRC_ZHI, hi);
        idle();
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!md_done && n < 100);
    endtask

    task automatic run_md(input logic [W-1:0] a, input logic [W-1:0] b, input logic div,
                          output logic [W-1:0] lo, output logic [W-1:0] hi, output int lat);
        load_y(a);
        drive(b); md_div = div; md_start = 1'b1; tick(); idle();
        check("md_busy after start", 32'(md_busy), 32'd1);
        wait_done(lat);
        check("md_busy low at done", 32'(md_busy), 32'd0);
        peek(SRC_ZLO, lo);
        peek(SRC_ZHI, hi);
        idle();
        tick();
        check("md_done single cycle", 32'(md_done), 32'd0);
    endtask

    // Reference ALU from the operation definitions.
    function automatic void alu_model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] lo, output logic [W-1:0] hi);
        int s;
        s  = int'(b[4:0]);
        hi = '0;
        case (op)
            0:  lo = a & b;
            1:  lo = a | b;
            2:  lo = a + b;
            3:  lo = a - b;
            4:  lo = a >> s;
            5:  lo = $signed(a) >>> s;
            6:  lo = a << s;
            7:  lo = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
            8:  lo = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
            9: begin
                lo = 32'd0 - b;
                hi = lo[31] ? '1 : '0;
            end
            10: lo = ~b;
            default: lo = '0;
        endcase
    endfunction

    // Reference signed multiply/divide using 64-bit integer arithmetic.
    function automatic void md_model(input logic div, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] lo, output logic [W-1:0] hi);
        longint sa, sb, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!div) begin
            p  = sa * sb;
            lo = p[31:0];
            hi = p[63:32];
        end else if (b == '0) begin
            lo = '1;
            hi = a;
        end else begin
            r  = sa / sb;
            p  = r;
            lo = p[31:0];
            r  = sa % sb;
            p  = r;
            hi = p[31:0];
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] lo, hi, elo, ehi, v, a, b;
        logic [W-1:0] rf_model [N];
        int lat, first_done, done_cnt, op;
        logic dv, ba;
        logic [3:0] r;

        tbl[0]  = '{4'd2,  32'd7,          32'd5,          32'd12,         32'd0};
        tbl[1]  = '{4'd3,  32'd7,          32'd5,          32'd2,          32'd0};
        tbl[2]  = '{4'd8,  32'h8000_0001,  32'd1,          32'h0000_0003,  32'd0};
        tbl[3]  = '{4'd0,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  32'd0};
        tbl[4]  = '{4'd1,  32'h0000_F000,  32'h0000_0F0F,  32'h0000_FF0F,  32'd0};
        tbl[5]  = '{4'd4,  32'h8000_0000,  32'd4,          32'h0800_0000,  32'd0};
        tbl[6]  = '{4'd5,  32'h8000_0000,  32'd4,          32'hF800_0000,  32'd0};
        tbl[7]  = '{4'd6,  32'd1,          32'd31,         32'h8000_0000,  32'd0};
        tbl[8]  = '{4'd7,  32'd1,          32'd1,          32'h8000_0000,  32'd0};
        tbl[9]  = '{4'd9,  32'h0000_1234,  32'd5,          32'hFFFF_FFFB,  32'hFFFF_FFFF};
        tbl[10] = '{4'd9,  32'h0000_1234,  32'hFFFF_FFFB,  32'd5,          32'd0};
        tbl[11] = '{4'd10, 32'd0,          32'h0F0F_0F0F,  32'hF0F0_F0F0,  32'd0};
        tbl[12] = '{4'd3,  32'd0,          32'd1,          32'hFFFF_FFFF,  32'd0};
        tbl[13] = '{4'd2,  32'hFFFF_FFFF,  32'd2,          32'd1,          32'd0};
        tbl[14] = '{4'd6,  32'd1,          32'h0000_0021,  32'd2,          32'd0};
        tbl[15] = '{4'd7,  32'h1234_5678,  32'd8,          32'h7812_3456,  32'd0};
        tbl[16] = '{4'd8,  32'h1234_5678,  32'd0,          32'h1234_5678,  32'd0};
        tbl[17] = '{4'd11, 32'd5,          32'd5,          32'd0,          32'd0};

        idle();
        csign = '0; mem_rdata = '0; in_data = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        peek(SRC_PC, v);  check("reset pc", v, 32'd0);
        peek(SRC_ZLO, v); check("reset zlo", v, 32'd0);
        check("reset md_busy", 32'(md_busy), 32'd0);
        check("reset md_done", 32'(md_done), 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset mar", mar, 32'd0);
        check("reset mdr", mdr, 32'd0);
        check("reset ir", ir, 32'd0);
        idle();

        // Register file against an array model, random writes and reads
        for (int i = 0; i < N; i++) rf_model[i] = '0;
        for (int i = 0; i < 24; i++) begin
            r = 4'($urandom_range(0, N - 1));
            v = $urandom;
            write_reg(r, v);
            rf_model[r] = v;
            r  = 4'($urandom_range(0, N - 1));
            ba = 1'($urandom_range(0, 1));
            rsel_out = r; ba_out = ba;
            peek(SRC_RSEL, v);
            check($sformatf("regfile read r%0d ba%0d", r, ba), v, (ba && r == 0) ? 32'd0 : rf_model[r]);
            idle();
        end

        // R1=7, R2=5 through the register file and ALU
        write_reg(4'd1, 32'd7);
        write_reg(4'd2, 32'd5);
        bus_src = SRC_RSEL; rsel_out = 4'd1; y_in = 1'b1; tick(); idle();
        bus_src = SRC_RSEL; rsel_out = 4'd2; alu_op = ALU_ADD; z_in = 1'b1; tick(); idle();
        peek(SRC_ZLO, v); check("R1+R2", v, 32'd12); idle();
        bus_src = SRC_RSEL; rsel_out = 4'd2; alu_op = ALU_SUB; z_in = 1'b1; tick(); idle();
        peek(SRC_ZLO, v); check("R1-R2", v, 32'd2); idle();

        // Table-driven ALU vectors
        for (int i = 0; i < 18; i++) begin
            alu_run(tbl[i].op, tbl[i].a, tbl[i].b, lo, hi);
            check($sformatf("alu vec%0d lo", i), lo, tbl[i].lo);
            check($sformatf("alu vec%0d hi", i), hi, tbl[i].hi);
        end

        // Random ALU operations against the model
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 10);
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            alu_run(4'(op), a, b, lo, hi);
            alu_model(op, a, b, elo, ehi);
            check($sformatf("alu rnd op%0d lo", op), lo, elo);
            check($sformatf("alu rnd op%0d hi", op), hi, ehi);
        end

        // MUL -3*4 with an ignored second start during the run
        load_y(32'hFFFF_FFFD);
        drive(32'd4); md_div = 1'b0; md_start = 1'b1; tick(); idle();
        check("mul busy after start", 32'(md_busy), 32'd1);
        first_done = 0; done_cnt = 0;
        for (int n = 1; n <= 45; n++) begin
            if (n == 5) begin
                drive(32'd100); md_div = 1'b1; md_start = 1'b1;
            end
            tick(); idle();
            if (md_done) begin
                done_cnt++;
                if (first_done == 0) first_done = n;
            end
        end
        check("mul latency", 32'(first_done), 32'd33);
        check("mul done pulses", 32'(done_cnt), 32'd1);
        peek(SRC_ZHI, v); check("mul -3*4 zhi", v, 32'hFFFF_FFFF);
        peek(SRC_ZLO, v); check("mul -3*4 zlo", v, 32'hFFFF_FFF4);
        idle();

        // Division corner cases
        run_md(32'd17, 32'd5, 1'b1, lo, hi, lat);
        check("div 17/5 lat", 32'(lat), 32'd33);
        check("div 17/5 zlo", lo, 32'd3);
        check("div 17/5 zhi", hi, 32'd2);
        run_md(-32'sd17, 32'd5, 1'b1, lo, hi, lat);
        check("div -17/5 zlo", lo, 32'hFFFF_FFFD);
        check("div -17/5 zhi", hi, 32'hFFFF_FFFE);
        run_md(32'd9, 32'd0, 1'b1, lo, hi, lat);
        check("div 9/0 lat", 32'(lat), 32'd1);
        check("div 9/0 zlo", lo, 32'hFFFF_FFFF);
        check("div 9/0 zhi", hi, 32'd9);

        // z_in during RUN loads Z; the engine overwrites it at completion
        load_y(32'd2);
        drive(32'd3); md_start = 1'b1; tick(); idle();
        tick(); tick(); tick();
        drive(32'h77); alu_op = ALU_OR; z_in = 1'b1; tick(); idle();
        peek(SRC_ZLO, v); check("z_in during run", v, 32'h77); idle();
        wait_done(lat);
        check("run z_in done seen", 32'(md_done), 32'd1);
        peek(SRC_ZLO, v); check("mul 2*3 after z_in", v, 32'd6); idle();

        // Random mul/div against the integer model
        for (int i = 0; i < 12; i++) begin
            dv = 1'($urandom_range(0, 1));
            a  = (i % 2 == 0) ? $urandom : 32'($signed(32'($urandom_range(0, 2000))) - 1000);
            b  = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($signed(32'($urandom_range(0, 60))) - 30));
            run_md(a, b, dv, lo, hi, lat);
            md_model(dv, a, b, elo, ehi);
            check($sformatf("md rnd div%0d lat", dv), 32'(lat), (dv && b == '0) ? 32'd1 : 32'd33);
            check($sformatf("md rnd div%0d zlo", dv), lo, elo);
            check($sformatf("md rnd div%0d zhi", dv), hi, ehi);
        end

        // Reset in the middle of a run aborts without a completion pulse
        load_y(32'd5);
        drive(32'd9); md_start = 1'b1; tick(); idle();
        for (int n = 0; n < 10; n++) tick();
        check("busy before abort", 32'(md_busy), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("busy after abort", 32'(md_busy), 32'd0);
        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (md_done) done_cnt++;
        end
        check("no done after abort", 32'(done_cnt), 32'd0);
        peek(SRC_ZHI, v); check("abort zhi", v, 32'd0);
        peek(SRC_ZLO, v); check("abort zlo", v, 32'd0);
        idle();
        run_md(32'd6, 32'd7, 1'b0, lo, hi, lat);
        check("mul 6*7 zlo", lo, 32'd42);
        check("mul 6*7 zhi", hi, 32'd0);

        // R0 masking with ba_out
        write_reg(4'd0, 32'h55);
        rsel_out = 4'd0; ba_out = 1'b1; peek(SRC_RSEL, v); check("ba_out R0", v, 32'd0);
        ba_out = 1'b0; #1; check("R0 plain", bus, 32'h55); idle();

        // Branch condition and PC/MAR sequencing
        drive(32'h0008_0000); ir_in = 1'b1; tick(); idle();
        check("ir load", ir, 32'h0008_0000);
        drive(32'd3); con_in = 1'b1; tick(); idle();
        drive(32'h10); pc_in = 1'b1; tick(); idle();
        csign = 32'd4; pc_in = 1'b1; inc_pc = 1'b1; tick(); idle();
        peek(SRC_PC, v); check("pc branch taken", v, 32'h15); idle();
        mar_in = 1'b1; inc_pc = 1'b1; tick(); idle();
        check("mar from pc", mar, 32'h15);
        drive(32'd0); con_in = 1'b1; tick(); idle();
        csign = 32'd4; pc_in = 1'b1; inc_pc = 1'b1; tick(); idle();
        peek(SRC_PC, v); check("pc not taken", v, 32'h16); idle();
        drive(32'h0018_0000); ir_in = 1'b1; tick(); idle();
        drive(32'hFFFF_FFF0); con_in = 1'b1; tick(); idle();
        csign = 32'd2; pc_in = 1'b1; inc_pc = 1'b1; tick(); idle();
        peek(SRC_PC, v); check("pc neg taken", v, 32'h19); idle();
        drive(32'h0010_0000); ir_in = 1'b1; tick(); idle();
        drive(32'd0); con_in = 1'b1; tick(); idle();
        csign = 32'd2; pc_in = 1'b1; inc_pc = 1'b1; tick(); idle();
        peek(SRC_PC, v); check("pc pos on zero", v, 32'h1A); idle();
        drive(32'hABC); mar_in = 1'b1; tick(); idle();
        check("mar from bus", mar, 32'hABC);

        // MDR, OUT, IN, HI/LO and Y paths
        mem_rdata = 32'hDEAD; read = 1'b1; mdr_in = 1'b1; tick(); idle();
        check("mdr from memory", mdr, 32'hDEAD);
        mem_rdata = 32'h1111; read = 1'b1; peek(SRC_MDR, v); check("mdr view read", v, 32'h1111);
        read = 1'b0; #1; check("mdr view reg", bus, 32'hDEAD); idle();
        drive(32'h42); mdr_in = 1'b1; tick(); idle();
        check("mdr from bus", mdr, 32'h42);
        drive(32'h99); out_in = 1'b1; tick(); idle();
        check("out_data", out_data, 32'h99);
        in_data = 32'h5A; tick();
        peek(SRC_IN, v); check("in sample", v, 32'h5A); idle();
        drive(32'h11); hi_in = 1'b1; tick(); idle();
        drive(32'h22); lo_in = 1'b1; tick(); idle();
        peek(SRC_HI, v); check("hi reg", v, 32'h11);
        peek(SRC_LO, v); check("lo reg", v, 32'h22); idle();
        load_y(32'h3C);
        peek(SRC_Y, v); check("y view", v, 32'h3C);
        peek(SRC_MAR, v); check("mar view", v, 32'hABC);
        peek(4'd13, v); check("unused source", v, 32'd0); idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
